// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Wishbone pipelined initiator turning single commands into bus transactions (optional WB_MASTER_TIMEOUT_EN)
module wb_cmd_master #(
    parameter int ADDR_WIDTH     = 4,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [3:0]            cmd_sel_i,
    input  logic [31:0]           cmd_dat_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_dat_o,
    output logic [1:0]            rsp_status_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [31:0]           wb_dat_o,
    input  logic                  wb_stall_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i,
    input  logic [31:0]           wb_dat_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_RETRY   = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [3:0]              sel_q, sel_d;
    logic [31:0]             dat_q, dat_d;
    logic [31:0]             rsp_dat_q, rsp_dat_d;
    logic [1:0]              rsp_status_q, rsp_status_d;
    logic [RW-1:0]           retry_q, retry_d;
    logic                    term_cycle;
    logic                    enter_req;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_expire;
    assign tmo_expire = (tmo_q == TMO_LAST);
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // The bus handshake signals come straight from the state; data/address are registered at accept
    assign cmd_ready_o  = (state_q == S_IDLE);
    assign wb_cyc_o     = (state_q == S_REQ) || (state_q == S_WAIT);
    assign wb_stb_o     = (state_q == S_REQ);
    assign wb_we_o      = we_q;
    assign wb_adr_o     = adr_q;
    assign wb_sel_o     = sel_q;
    assign wb_dat_o     = dat_q;
    assign rsp_valid_o  = (state_q == S_RESP);
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_status_o = rsp_status_q;

    // A termination is only seen in WAIT, or in REQ on the cycle the strobe is accepted
    assign term_cycle = (state_q == S_WAIT) || ((state_q == S_REQ) && !wb_stall_i);

    // Next-state and datapath updates; termination priority err > ack > rty > timeout
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        adr_d        = adr_q;
        sel_d        = sel_q;
        dat_d        = dat_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;
        retry_d      = retry_q;
        enter_req    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    we_d      = cmd_we_i;
                    adr_d     = cmd_adr_i;
                    sel_d     = cmd_sel_i;
                    dat_d     = cmd_dat_i;
                    state_d   = S_REQ;
                    enter_req = 1'b1;
                end
            end
            S_REQ, S_WAIT: begin
                if (term_cycle && wb_err_i) begin
                    rsp_status_d = ST_ERR;
                    rsp_dat_d    = 32'd0;
                    state_d      = S_RESP;
                end else if (term_cycle && wb_ack_i) begin
                    rsp_status_d = ST_OK;
                    rsp_dat_d    = we_q ? 32'd0 : wb_dat_i;
                    state_d      = S_RESP;
                end else if (term_cycle && wb_rty_i) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d   = retry_q + 1'b1;
                        state_d   = S_REQ;
                        enter_req = 1'b1;
                    end else begin
                        rsp_status_d = ST_RETRY;
                        rsp_dat_d    = 32'd0;
                        state_d      = S_RESP;
                    end
`ifdef WB_MASTER_TIMEOUT_EN
                end else if (tmo_expire) begin
                    rsp_status_d = ST_TIMEOUT;
                    rsp_dat_d    = 32'd0;
                    state_d      = S_RESP;
`endif
                end else if ((state_q == S_REQ) && !wb_stall_i) begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                    retry_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef WB_MASTER_TIMEOUT_EN
    // Counts cycles of the current strobe attempt; restarts each time REQ is (re)entered
    always_comb begin
        tmo_d = tmo_q;
        if (enter_req) begin
            tmo_d = '0;
        end else if (wb_cyc_o) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Timeout counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            adr_q        <= '0;
            sel_q        <= 4'd0;
            dat_q        <= 32'd0;
            rsp_dat_q    <= 32'd0;
            rsp_status_q <= ST_OK;
            retry_q      <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            sel_q        <= sel_d;
            dat_q        <= dat_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
            retry_q      <= retry_d;
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - directed self-checking bench for wb_cmd_master
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [3:0]  cmd_adr, cmd_sel;
    logic [31:0] cmd_dat;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic        cyc, stb, we;
    logic [3:0]  adr, sel;
    logic [31:0] dat_o;
    logic        stall, ack, err, rty;
    logic [31:0] dat_i;

    int checks = 0;
    int failures = 0;
    int n, strobes, rtys;

    always #5 clk = ~clk;

    wb_cmd_master #(
        .ADDR_WIDTH(4),
        .MAX_RETRY(3),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_sel_i(cmd_sel), .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_dat_o(rsp_dat), .rsp_status_o(rsp_status),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr),
        .wb_sel_o(sel), .wb_dat_o(dat_o),
        .wb_stall_i(stall), .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty),
        .wb_dat_i(dat_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [3:0] a, input logic [31:0] d);
        cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_sel = 4'hF; cmd_dat = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_cleared", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_sel = 0; cmd_dat = 0;
        rsp_ready = 0; stall = 0; ack = 0; err = 0; rty = 0; dat_i = 0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_cyc", {31'd0, cyc}, 32'd0);
        chk("rst_stb", {31'd0, stb}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_adr", {28'd0, adr}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_status", {30'd0, rsp_status}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // write, ack one cycle after the strobe
        issue(1'b1, 4'h8, 32'hDEADBEEF);
        chk("wr_stb", {31'd0, stb}, 32'd1);
        chk("wr_cyc", {31'd0, cyc}, 32'd1);
        chk("wr_we", {31'd0, we}, 32'd1);
        chk("wr_adr", {28'd0, adr}, 32'h8);
        chk("wr_dat", dat_o, 32'hDEADBEEF);
        chk("wr_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        tick();
        chk("wr_wait_stb", {31'd0, stb}, 32'd0);
        chk("wr_wait_cyc", {31'd0, cyc}, 32'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("wr_rsp_cyc", {31'd0, cyc}, 32'd0);
        chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("wr_rsp_status", {30'd0, rsp_status}, 32'd0);
        chk("wr_rsp_dat", rsp_dat, 32'd0);
        consume();

        // read with three stall cycles, then ack
        issue(1'b0, 4'h4, 32'd0);
        stall = 1'b1;
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            if (stb) strobes++;
            tick();
        end
        stall = 1'b0; ack = 1'b1; dat_i = 32'h12345678;
        if (stb) strobes++;
        tick();
        ack = 1'b0; dat_i = 32'd0;
        chk("rd_stall_strobes", strobes, 32'd4);
        chk("rd_stall_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rd_stall_dat", rsp_dat, 32'h12345678);
        chk("rd_stall_status", {30'd0, rsp_status}, 32'd0);
        consume();

        // retry exhausted: rty on every strobe
        issue(1'b0, 4'h0, 32'd0);
        rty = 1'b1; n = 0; strobes = 0;
        while (!rsp_valid && n < 20) begin
            if (stb) strobes++;
            tick(); n++;
        end
        rty = 1'b0;
        chk("rty_ex_strobes", strobes, 32'd4);
        chk("rty_ex_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rty_ex_status", {30'd0, rsp_status}, 32'd2);
        chk("rty_ex_dat", rsp_dat, 32'd0);
        consume();

        // two retries in WAIT, then ack
        issue(1'b0, 4'h0, 32'd0);
        n = 0; strobes = 0; rtys = 0;
        while (!rsp_valid && n < 30) begin
            rty = 1'b0; ack = 1'b0;
            if (stb) strobes++;
            else if (cyc) begin
                if (rtys < 2) begin rty = 1'b1; rtys++; end
                else begin ack = 1'b1; dat_i = 32'hA5A5A5A5; end
            end
            tick(); n++;
        end
        rty = 1'b0; ack = 1'b0; dat_i = 32'd0;
        chk("rty2_strobes", strobes, 32'd3);
        chk("rty2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rty2_status", {30'd0, rsp_status}, 32'd0);
        chk("rty2_dat", rsp_dat, 32'hA5A5A5A5);
        consume();

        // err and ack together, response held with rsp_ready low
        issue(1'b0, 4'h2, 32'd0);
        err = 1'b1; ack = 1'b1; dat_i = 32'hFFFF0000;
        tick();
        err = 1'b0; ack = 1'b0; dat_i = 32'd0;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 4'h6;
        for (int i = 0; i < 5; i++) begin
            chk("err_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("err_hold_status", {30'd0, rsp_status}, 32'd1);
            chk("err_hold_dat", rsp_dat, 32'd0);
            chk("err_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("err_hold_cyc", {31'd0, cyc}, 32'd0);
            tick();
        end
        cmd_valid = 1'b0;
        consume();
        chk("err_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // silent slave
        issue(1'b0, 4'h1, 32'd0);
`ifdef WB_MASTER_TIMEOUT_EN
        n = 0;
        while (cyc && n < 40) begin
            tick(); n++;
        end
        chk("tmo_cycles", n, 32'd16);
        chk("tmo_valid", {31'd0, rsp_valid}, 32'd1);
        chk("tmo_status", {30'd0, rsp_status}, 32'd3);
        chk("tmo_dat", rsp_dat, 32'd0);
        consume();
`else
        repeat (100) tick();
        chk("hang_cyc", {31'd0, cyc}, 32'd1);
        chk("hang_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif

        // reset while in WAIT, then a minimum-latency write
        issue(1'b1, 4'h3, 32'h11111111);
        tick();
        chk("rstw_pre_cyc", {31'd0, cyc}, 32'd1);
        chk("rstw_pre_stb", {31'd0, stb}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_cyc", {31'd0, cyc}, 32'd0);
        chk("rstw_stb", {31'd0, stb}, 32'd0);
        chk("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rstw_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        issue(1'b1, 4'hC, 32'h0BADF00D);
        chk("post_stb", {31'd0, stb}, 32'd1);
        chk("post_adr", {28'd0, adr}, 32'hC);
        chk("post_dat", dat_o, 32'h0BADF00D);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("post_valid", {31'd0, rsp_valid}, 32'd1);
        chk("post_status", {30'd0, rsp_status}, 32'd0);
        chk("post_rdat", rsp_dat, 32'd0);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
